input_capture: RTL and testbench

INPUT_CAPTURE -- requirements
Module: input_capture

---
 rtl/input_capture.sv | 164 ++++++++++++++++
 tb/tb_input_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/input_capture.sv
// Pushbutton capture for the game FSM: 2-flop synchronizer, optional debounce filter
// (INPUT_CAPTURE_DEBOUNCE_EN), and a press classifier emitting press_valid / multi_press pulses.
module input_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       enable,
  output logic [3:0] player_input,
  output logic       press_valid,
  output logic       multi_press
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("input_capture: DEBOUNCE_CYCLES out of range or CNT_W too narrow");
  end

  typedef enum logic [1:0] {
    StReleaseWait,
    StIdle,
    StHeld
  } state_e;

  logic [3:0] sync_meta_q;
  logic [3:0] sync_q;
  logic [3:0] deb;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= buttons;
      sync_q      <= sync_meta_q;
    end
  end

`ifdef INPUT_CAPTURE_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned      WarmCycles = DEBOUNCE_CYCLES + 2;

  logic [3:0]       cand_q, cand_d;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // deb follows the next-state count so a clean edge lands exactly N+2 cycles after the raw edge.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    deb_d = (cnt_d == CntMax) ? cand_d : deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb = deb_q;
`else
  localparam int unsigned WarmCycles = 2;

  assign deb = sync_q;
`endif

  // After reset deb reads 0 until the pipeline refills; hold RELEASE_WAIT until then so a
  // button held through reset is not mistaken for a release.
  localparam int unsigned   WarmW   = CNT_W + 1;
  localparam logic [WarmW-1:0] WarmMax = WarmW'(WarmCycles);

  logic [WarmW-1:0] warm_q;
  logic             ready;

  assign ready = (warm_q == WarmMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q <= '0;
    end else if (!ready) begin
      warm_q <= warm_q + 1'b1;
    end
  end

  state_e     state_q, state_d;
  logic [3:0] player_input_q, player_input_d;
  logic       press_valid_q, press_valid_d;
  logic       multi_press_q, multi_press_d;
  logic       deb_zero;
  logic       deb_one_hot;

  assign deb_zero    = (deb == 4'b0000);
  assign deb_one_hot = $onehot(deb);

  always_comb begin
    state_d        = state_q;
    player_input_d = player_input_q;
    press_valid_d  = 1'b0;
    multi_press_d  = 1'b0;
    unique case (state_q)
      StReleaseWait: begin
        if (ready && enable && deb_zero) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (!enable) begin
          state_d = StReleaseWait;
        end else if (deb_one_hot) begin
          state_d        = StHeld;
          player_input_d = deb;
        end else if (!deb_zero) begin
          state_d       = StReleaseWait;
          multi_press_d = 1'b1;
        end
      end
      StHeld: begin
        if (!enable) begin
          state_d = StReleaseWait;
        end else if (deb_zero) begin
          state_d       = StIdle;
          press_valid_d = 1'b1;
        end else if (deb != player_input_q) begin
          state_d       = StReleaseWait;
          multi_press_d = 1'b1;
        end
      end
      default: state_d = StReleaseWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StReleaseWait;
      player_input_q <= '0;
      press_valid_q  <= 1'b0;
      multi_press_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      player_input_q <= player_input_d;
      press_valid_q  <= press_valid_d;
      multi_press_q  <= multi_press_d;
    end
  end

  assign player_input = player_input_q;
  assign press_valid  = press_valid_q;
  assign multi_press  = multi_press_q;

endmodule

// File: tb/tb_input_capture.sv
// Directed self-checking bench for input_capture; latencies adapt to INPUT_CAPTURE_DEBOUNCE_EN.
module tb_input_capture;

  localparam int unsigned N = 4;
`ifdef INPUT_CAPTURE_DEBOUNCE_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] buttons;
  logic       enable;
  logic [3:0] player_input;
  logic       press_valid;
  logic       multi_press;

  input_capture #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons     (buttons),
    .enable      (enable),
    .player_input(player_input),
    .press_valid (press_valid),
    .multi_press (multi_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pv_cnt = 0;
  int mp_cnt = 0;
  int pv0;
  int mp0;

  always @(negedge clk) begin
    if (press_valid) pv_cnt <= pv_cnt + 1;
    if (multi_press) mp_cnt <= mp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    buttons = 4'b0000;
    tick(3);
    check("rst_pi", 32'(player_input), 32'h0);
    check("rst_pv", 32'(press_valid), 32'h0);
    check("rst_mp", 32'(multi_press), 32'h0);
    reset  = 1'b0;
    enable = 1'b1;
    tick(LAT + 6);

    // Single press 0100, held 10 cycles
    pv0 = pv_cnt;
    mp0 = mp_cnt;
    buttons = 4'b0100;
    tick(LAT);
    check("single_pi_early", 32'(player_input), 32'h0);
    tick(1);
    check("single_pi", 32'(player_input), 32'h4);
    tick(9 - LAT);
    buttons = 4'b0000;
    tick(LAT);
    check("single_pv_early", 32'(press_valid), 32'h0);
    tick(1);
    check("single_pv", 32'(press_valid), 32'h1);
    tick(1);
    check("single_pv_drop", 32'(press_valid), 32'h0);
    check("single_pv_count", 32'(pv_cnt - pv0), 32'h1);
    check("single_mp_count", 32'(mp_cnt - mp0), 32'h0);
    tick(4);

    // Multi press 1001 is rejected, then a normal press 0001
    pv0 = pv_cnt;
    mp0 = mp_cnt;
    buttons = 4'b1001;
    tick(LAT + 1);
    check("multi_mp", 32'(multi_press), 32'h1);
    check("multi_pi_kept", 32'(player_input), 32'h4);
    tick(9 - LAT);
    buttons = 4'b0000;
    tick(LAT + 4);
    check("multi_pv_count", 32'(pv_cnt - pv0), 32'h0);
    check("multi_mp_count", 32'(mp_cnt - mp0), 32'h1);
    buttons = 4'b0001;
    tick(LAT + 1);
    check("after_multi_pi", 32'(player_input), 32'h1);
    tick(4);
    buttons = 4'b0000;
    tick(LAT + 1);
    check("after_multi_pv", 32'(press_valid), 32'h1);
    tick(4);

    // Button held while enable is low is ignored until released
    enable = 1'b0;
    tick(2);
    pv0 = pv_cnt;
    mp0 = mp_cnt;
    buttons = 4'b0010;
    tick(LAT + 5);
    enable = 1'b1;
    tick(LAT + 5);
    check("gate_pv_count", 32'(pv_cnt - pv0), 32'h0);
    check("gate_mp_count", 32'(mp_cnt - mp0), 32'h0);
    check("gate_pi_kept", 32'(player_input), 32'h1);
    buttons = 4'b0000;
    tick(LAT + 3);
    buttons = 4'b0010;
    tick(LAT + 1);
    check("gate_pi", 32'(player_input), 32'h2);
    tick(3);
    buttons = 4'b0000;
    tick(LAT + 1);
    check("gate_pv", 32'(press_valid), 32'h1);
    tick(4);

`ifdef INPUT_CAPTURE_DEBOUNCE_EN
    // Bounce: 2-cycle runs never survive a 4-cycle filter
    pv0 = pv_cnt;
    mp0 = mp_cnt;
    for (int i = 0; i < 3; i++) begin
      buttons = 4'b0001;
      tick(2);
      buttons = 4'b0000;
      tick(2);
    end
    buttons = 4'b0001;
    tick(LAT);
    check("bounce_pi_early", 32'(player_input), 32'h2);
    tick(1);
    check("bounce_pi", 32'(player_input), 32'h1);
    check("bounce_pv_count", 32'(pv_cnt - pv0), 32'h0);
    check("bounce_mp_count", 32'(mp_cnt - mp0), 32'h0);
    tick(3);
    buttons = 4'b0000;
    tick(LAT + 1);
    check("bounce_pv", 32'(press_valid), 32'h1);
    tick(4);
`endif

    // Reset in the middle of a held press
    buttons = 4'b1000;
    tick(LAT + 1);
    check("rstmid_pi_held", 32'(player_input), 32'h8);
    pv0 = pv_cnt;
    mp0 = mp_cnt;
    reset = 1'b1;
    tick(1);
    check("rstmid_pi", 32'(player_input), 32'h0);
    check("rstmid_pv", 32'(press_valid), 32'h0);
    check("rstmid_mp", 32'(multi_press), 32'h0);
    reset = 1'b0;
    tick(LAT + 6);
    buttons = 4'b0000;
    tick(LAT + 6);
    check("rstmid_pv_count", 32'(pv_cnt - pv0), 32'h0);
    check("rstmid_mp_count", 32'(mp_cnt - mp0), 32'h0);
    check("rstmid_pi_after", 32'(player_input), 32'h0);
    buttons = 4'b0100;
    tick(LAT + 1);
    check("recover_pi", 32'(player_input), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
